// File: rtl/memory_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : memory_sequencer
// Description: Arbitrates instruction-fetch and data requests onto a single
//              memory. Each granted request expands into a fixed memory op
//              sequence and completes with a one-cycle ack. Optional PC jump
//              support is enabled by defining MEMORY_SEQUENCER_JUMP_EN.
//              mem_op encoding: 0 NOP, 1 READ, 2 WRITE, 3 ABSOLUTE,
//              4 REL_ADD, 5 REL_SUB.
// Revision   : 1.0 - initial release
// ============================================================================
module memory_sequencer #(
    parameter int         FETCH_PRIORITY = 0,
    parameter logic [7:0] PC_STEP        = 8'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    output logic        fetch_ack,
    output logic [15:0] fetch_instr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [7:0]  data_addr,
    input  logic        data_word,
    input  logic [7:0]  data_wdata,
    output logic        data_ack,
    output logic [7:0]  data_rdata,
    output logic [2:0]  mem_op,
    output logic        mem_bus_sel,
    output logic        mem_word_sel,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
`ifdef MEMORY_SEQUENCER_JUMP_EN
    input  logic        jump_req,
    input  logic [1:0]  jump_mode,
    input  logic [7:0]  jump_offset,
    output logic        jump_ack,
`endif
    output logic        busy
);

    localparam logic [2:0] c_OP_NOP      = 3'd0;
    localparam logic [2:0] c_OP_READ     = 3'd1;
    localparam logic [2:0] c_OP_WRITE    = 3'd2;
    localparam logic [2:0] c_OP_ABSOLUTE = 3'd3;
    localparam logic [2:0] c_OP_REL_ADD  = 3'd4;
    localparam logic [2:0] c_OP_REL_SUB  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_RD0  = 4'd1,
        S_F_CAP0 = 4'd2,
        S_F_RD1  = 4'd3,
        S_F_CAP1 = 4'd4,
        S_F_INC  = 4'd5,
        S_D_SETA = 4'd6,
        S_D_RD   = 4'd7,
        S_D_CAP  = 4'd8,
        S_D_DONE = 4'd9,
        S_D_WR   = 4'd10,
        S_J_EXEC = 4'd11
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_fetch;
    logic        r_we;
    logic        r_word;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [15:0] r_instr;
    logic [7:0]  r_rdata;

    logic w_jump_pending;
    logic w_fetch_wins;
    logic w_grant_jump;
    logic w_grant_fetch;
    logic w_grant_data;

`ifdef MEMORY_SEQUENCER_JUMP_EN
    logic [1:0] r_jmode;
    logic [7:0] r_joffset;
    assign w_jump_pending = jump_req;
`else
    assign w_jump_pending = 1'b0;
`endif

    assign busy        = (r_state != S_IDLE);
    assign fetch_instr = r_instr;
    assign data_rdata  = r_rdata;

    // Round-robin: on contention, grant whichever side did not win last time.
    always_comb begin
        w_fetch_wins  = (FETCH_PRIORITY != 0) || !r_last_fetch;
        w_grant_jump  = 1'b0;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_jump_pending) begin
                w_grant_jump = 1'b1;
            end else if (fetch_req && data_req) begin
                w_grant_fetch = w_fetch_wins;
                w_grant_data  = !w_fetch_wins;
            end else begin
                w_grant_fetch = fetch_req;
                w_grant_data  = data_req;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_fetch <= 1'b0;
            r_we         <= 1'b0;
            r_word       <= 1'b0;
            r_addr       <= 8'h00;
            r_wdata      <= 8'h00;
            r_instr      <= 16'h0000;
            r_rdata      <= 8'h00;
`ifdef MEMORY_SEQUENCER_JUMP_EN
            r_jmode      <= 2'd0;
            r_joffset    <= 8'h00;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_grant_fetch) begin
                r_last_fetch <= 1'b1;
            end
            if (w_grant_data) begin
                r_last_fetch <= 1'b0;
                r_we         <= data_we;
                r_word       <= data_word;
                r_addr       <= data_addr;
                r_wdata      <= data_wdata;
            end
`ifdef MEMORY_SEQUENCER_JUMP_EN
            if (w_grant_jump) begin
                r_jmode   <= jump_mode;
                r_joffset <= jump_offset;
            end
`endif
            // Memory only drives its output during the second READ cycle.
            if (r_state == S_F_CAP0) begin
                r_instr[15:8] <= mem_rdata;
            end
            if (r_state == S_F_CAP1) begin
                r_instr[7:0] <= mem_rdata;
            end
            if (r_state == S_D_CAP) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_op       = c_OP_NOP;
        mem_bus_sel  = 1'b0;
        mem_word_sel = 1'b0;
        mem_wdata    = 8'h00;
        fetch_ack    = 1'b0;
        data_ack     = 1'b0;
`ifdef MEMORY_SEQUENCER_JUMP_EN
        jump_ack     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_grant_jump) begin
                    w_next_state = S_J_EXEC;
                end else if (w_grant_fetch) begin
                    w_next_state = S_F_RD0;
                end else if (w_grant_data) begin
                    w_next_state = S_D_SETA;
                end
            end
            S_F_RD0: begin
                mem_op       = c_OP_READ;
                mem_bus_sel  = 1'b1;
                w_next_state = S_F_CAP0;
            end
            S_F_CAP0: begin
                mem_op       = c_OP_READ;
                mem_bus_sel  = 1'b1;
                w_next_state = S_F_RD1;
            end
            S_F_RD1: begin
                mem_op       = c_OP_READ;
                mem_bus_sel  = 1'b1;
                mem_word_sel = 1'b1;
                w_next_state = S_F_CAP1;
            end
            S_F_CAP1: begin
                mem_op       = c_OP_READ;
                mem_bus_sel  = 1'b1;
                mem_word_sel = 1'b1;
                w_next_state = S_F_INC;
            end
            S_F_INC: begin
                mem_op       = c_OP_REL_ADD;
                mem_bus_sel  = 1'b1;
                mem_wdata    = PC_STEP;
                fetch_ack    = 1'b1;
                w_next_state = S_IDLE;
            end
            S_D_SETA: begin
                mem_op       = c_OP_ABSOLUTE;
                mem_wdata    = r_addr;
                w_next_state = r_we ? S_D_WR : S_D_RD;
            end
            S_D_RD: begin
                mem_op       = c_OP_READ;
                mem_word_sel = r_word;
                w_next_state = S_D_CAP;
            end
            S_D_CAP: begin
                mem_op       = c_OP_READ;
                mem_word_sel = r_word;
                w_next_state = S_D_DONE;
            end
            S_D_DONE: begin
                data_ack     = 1'b1;
                w_next_state = S_IDLE;
            end
            S_D_WR: begin
                mem_op       = c_OP_WRITE;
                mem_word_sel = r_word;
                mem_wdata    = r_wdata;
                data_ack     = 1'b1;
                w_next_state = S_IDLE;
            end
            S_J_EXEC: begin
`ifdef MEMORY_SEQUENCER_JUMP_EN
                mem_bus_sel = 1'b1;
                mem_wdata   = r_joffset;
                jump_ack    = 1'b1;
                case (r_jmode)
                    2'd0:    mem_op = c_OP_ABSOLUTE;
                    2'd1:    mem_op = c_OP_REL_ADD;
                    2'd2:    mem_op = c_OP_REL_SUB;
                    default: mem_op = c_OP_NOP;
                endcase
`endif
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
